// File: rtl/pipeline_ctrl_if.sv
// Hazard/control bundle between the decode-side pipeline and pipeline_ctrl.
// The slave modport is the controller's view; master is the pipeline/driver side.
interface pipeline_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_jump;
    logic        id_jr;
    logic [4:0]  ex_wr_addr;
    logic        ex_regWr;
    logic        ex_memToReg;
    logic [4:0]  mem_wr_addr;
    logic        mem_regWr;
    logic        mem_memToReg;
    logic        ex_br_taken;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [1:0]  pc_sel;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jr,
               ex_wr_addr, ex_regWr, ex_memToReg,
               mem_wr_addr, mem_regWr, mem_memToReg, ex_br_taken,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, pc_sel,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jr,
               ex_wr_addr, ex_regWr, ex_memToReg,
               mem_wr_addr, mem_regWr, mem_memToReg, ex_br_taken,
        output pc_en, ifid_en, ifid_flush, idex_bubble, pc_sel,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Load-use stall and control-flow flush controller for a 5-stage pipeline.
// Outputs are combinational from inputs and state; counters saturate.
module pipeline_ctrl (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic {RUN, STALL} state_e;

    state_e      state_q, state_d;
    logic [1:0]  stall_left_q, stall_left_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic        hz_ex, hz_mem, stall;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0]  pc_sel;

    // Register 0 is hardwired, so a write to it can never feed a consumer.
    function automatic logic match(input logic [4:0] r, input logic [4:0] w,
                                   input logic en);
        return en && (r == w) && (w != 5'd0);
    endfunction

    always_comb begin
        hz_ex  = bus.ex_regWr && bus.ex_memToReg &&
                 (match(bus.id_rs, bus.ex_wr_addr, bus.id_use_rs) ||
                  match(bus.id_rt, bus.ex_wr_addr, bus.id_use_rt));
        hz_mem = bus.mem_regWr && bus.mem_memToReg &&
                 (match(bus.id_rs, bus.mem_wr_addr, bus.id_use_rs) ||
                  match(bus.id_rt, bus.mem_wr_addr, bus.id_use_rt));
    end

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        stall        = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pc_sel       = 2'b00;

        if (reset) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            state_d      = RUN;
            stall_left_d = 2'd0;
        end else if (bus.ex_br_taken) begin
            // A taken branch squashes everything younger, including a pending stall.
            pc_sel       = 2'b11;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            state_d      = RUN;
            stall_left_d = 2'd0;
        end else if (state_q == STALL) begin
            stall = 1'b1;
            if (stall_left_q != 2'd0) stall_left_d = stall_left_q - 2'd1;
            if (stall_left_q <= 2'd1) state_d = RUN;
        end else if (hz_ex) begin
            stall        = 1'b1;
            state_d      = STALL;
            stall_left_d = 2'd1;
        end else if (hz_mem) begin
            stall = 1'b1;
        end else if (bus.id_jump) begin
            pc_sel     = 2'b01;
            ifid_flush = 1'b1;
        end else if (bus.id_jr) begin
            pc_sel     = 2'b10;
            ifid_flush = 1'b1;
        end

        if (stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset) begin
            stall_cnt_d = 16'd0;
            flush_cnt_d = 16'd0;
        end else begin
            if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
            if (ifid_flush && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        stall_left_q <= stall_left_d;
        stall_cnt_q  <= stall_cnt_d;
        flush_cnt_q  <= flush_cnt_d;
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.pc_sel      = pc_sel;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand sequences for the
// multi-cycle corners, counter saturation, and randomized run against a model.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic reset;
    pipeline_ctrl_if ifc ();

    pipeline_ctrl dut (.clk(clk), .reset(reset), .bus(ifc.slave));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt;
        logic       urs, urt, jump, jr;
        logic [4:0] exa;
        logic       exrw, exm2r;
        logic [4:0] mema;
        logic       memrw, memm2r;
        logic       br;
        logic [5:0] exp;  // {pc_en, ifid_en, ifid_flush, idex_bubble, pc_sel}
    } vec_t;

    localparam logic [5:0] O_RUN = 6'b110000;
    localparam logic [5:0] O_STL = 6'b000100;
    localparam logic [5:0] O_JMP = 6'b111001;
    localparam logic [5:0] O_JR  = 6'b111010;
    localparam logic [5:0] O_BR  = 6'b111111;
    localparam logic [5:0] O_RST = 6'b111100;

    function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt,
                                logic urs, logic urt, logic jump, logic jr,
                                logic [4:0] exa, logic exrw, logic exm2r,
                                logic [4:0] mema, logic memrw, logic memm2r,
                                logic br, logic [5:0] exp);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.jump = jump; v.jr = jr; v.exa = exa; v.exrw = exrw; v.exm2r = exm2r;
        v.mema = mema; v.memrw = memrw; v.memm2r = memm2r; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset               = v.rst;
        ifc.id_rs           = v.rs;
        ifc.id_rt           = v.rt;
        ifc.id_use_rs       = v.urs;
        ifc.id_use_rt       = v.urt;
        ifc.id_jump         = v.jump;
        ifc.id_jr           = v.jr;
        ifc.ex_wr_addr      = v.exa;
        ifc.ex_regWr        = v.exrw;
        ifc.ex_memToReg     = v.exm2r;
        ifc.mem_wr_addr     = v.mema;
        ifc.mem_regWr       = v.memrw;
        ifc.mem_memToReg    = v.memm2r;
        ifc.ex_br_taken     = v.br;
    endtask

    function automatic logic [5:0] outs();
        return {ifc.pc_en, ifc.ifid_en, ifc.ifid_flush, ifc.idex_bubble, ifc.pc_sel};
    endfunction

    // Apply one cycle's inputs at the falling edge and check outputs 1ns later.
    task automatic step(input string nm, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk(nm, {26'd0, outs()}, {26'd0, v.exp});
    endtask

    vec_t idle_v, rst_v;
    vec_t tbl[$];

    task automatic do_reset();
        step("reset_outs", rst_v);
    endtask

    // Reference model: stall window tracked as an absolute cycle deadline.
    function automatic logic m(logic [4:0] r, logic [4:0] w, logic en);
        return en && (r == w) && (w != 0);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        idle_v = mk(0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0, O_RUN);
        rst_v  = mk(1, 0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0, O_RST);
        drive(rst_v);

        tbl.push_back(idle_v);
        tbl.push_back(mk(0, 8,3, 1,1, 0,0, 8,1,1, 0,0,0, 0, O_STL)); // lw $8 EX, rs=8
        tbl.push_back(mk(0, 1,9, 0,1, 0,0, 0,0,0, 9,1,1, 0, O_STL)); // lw $9 MEM, rt=9
        tbl.push_back(mk(0, 1,9, 0,0, 0,0, 0,0,0, 9,1,1, 0, O_RUN)); // rt not used
        tbl.push_back(mk(0, 0,0, 1,1, 0,0, 0,1,1, 0,0,0, 0, O_RUN)); // lw $0
        tbl.push_back(mk(0, 8,0, 1,0, 0,0, 8,1,0, 0,0,0, 0, O_RUN)); // ALU result in EX
        tbl.push_back(mk(0, 0,0, 0,0, 1,0, 0,0,0, 0,0,0, 0, O_JMP));
        tbl.push_back(mk(0, 4,0, 1,0, 0,1, 0,0,0, 0,0,0, 0, O_JR));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0, 1, O_BR));
        tbl.push_back(mk(0, 8,0, 1,0, 1,0, 8,1,1, 0,0,0, 1, O_BR));  // branch beats hazard
        tbl.push_back(mk(0, 8,0, 1,0, 1,0, 8,1,1, 0,0,0, 0, O_STL)); // stall masks jump
        tbl.push_back(mk(1, 8,0, 1,0, 1,0, 8,1,1, 0,0,0, 1, O_RST)); // reset dominates
        tbl.push_back(mk(0, 8,0, 1,0, 0,0, 8,0,1, 0,0,0, 0, O_RUN)); // no regWr
        tbl.push_back(mk(0, 7,0, 1,0, 0,0, 0,0,0, 7,1,0, 0, O_RUN)); // ALU result in MEM
        tbl.push_back(mk(0, 5,5, 0,1, 0,0, 5,1,1, 5,1,1, 0, O_STL)); // both stages match

        for (int i = 0; i < tbl.size(); i++) begin
            do_reset();
            step($sformatf("vec%0d", i), tbl[i]);
            chk($sformatf("vec%0d_stall_cnt0", i), {16'd0, ifc.stall_cnt}, 32'd0);
        end

        // Load-use from EX: two stall cycles, then RUN.
        do_reset();
        step("lu_c1", mk(0, 8,0, 1,0, 0,0, 8,1,1, 0,0,0, 0, O_STL));
        step("lu_c2", mk(0, 8,0, 1,0, 0,0, 0,0,0, 8,1,1, 0, O_STL));
        step("lu_c3", idle_v);
        chk("lu_stall_cnt", {16'd0, ifc.stall_cnt}, 32'd2);
        chk("lu_flush_cnt", {16'd0, ifc.flush_cnt}, 32'd0);

        // MEM-only load-use stalls once, state stays RUN.
        do_reset();
        step("mem_c1", mk(0, 0,9, 0,1, 0,0, 0,0,0, 9,1,1, 0, O_STL));
        step("mem_c2", idle_v);
        chk("mem_stall_cnt", {16'd0, ifc.stall_cnt}, 32'd1);

        // Taken branch in the second stall cycle.
        do_reset();
        step("br_c1", mk(0, 8,0, 1,0, 0,0, 8,1,1, 0,0,0, 0, O_STL));
        step("br_c2", mk(0, 8,0, 1,0, 0,0, 0,0,0, 8,1,1, 1, O_BR));
        step("br_c3", idle_v);
        chk("br_flush_cnt", {16'd0, ifc.flush_cnt}, 32'd1);
        chk("br_stall_cnt", {16'd0, ifc.stall_cnt}, 32'd1);

        // jr held through a load-use stall is serviced afterwards.
        do_reset();
        step("jr_c1", mk(0, 8,0, 1,0, 0,1, 8,1,1, 0,0,0, 0, O_STL));
        step("jr_c2", mk(0, 8,0, 1,0, 0,1, 0,0,0, 8,1,1, 0, O_STL));
        step("jr_c3", mk(0, 8,0, 1,0, 0,1, 0,0,0, 0,0,0, 0, O_JR));
        step("jr_c4", idle_v);
        chk("jr_flush_cnt", {16'd0, ifc.flush_cnt}, 32'd1);

        // Reset mid-stall.
        do_reset();
        step("rs_c1", mk(0, 8,0, 1,0, 0,0, 8,1,1, 0,0,0, 0, O_STL));
        step("rs_c2", mk(1, 8,0, 1,0, 0,0, 0,0,0, 8,1,1, 0, O_RST));
        step("rs_c3", idle_v);
        chk("rs_stall_cnt", {16'd0, ifc.stall_cnt}, 32'd0);
        chk("rs_flush_cnt", {16'd0, ifc.flush_cnt}, 32'd0);

        // Stall counter saturation via a continuous MEM hazard.
        do_reset();
        v = mk(0, 3,0, 1,0, 0,0, 0,0,0, 3,1,1, 0, O_STL);
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            drive(v);
        end
        #1;
        chk("sat_fffe", {16'd0, ifc.stall_cnt}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) step("sat_stall", v);
        chk("sat_ffff", {16'd0, ifc.stall_cnt}, 32'h0000FFFF);

        // Randomized run against the reference model.
        begin
            int cyc = 0;
            int stall_until = -1;
            int scnt = 0, fcnt = 0;
            for (int i = 0; i < 3000; i++) begin
                logic st, hex, hmem;
                logic [5:0] exp;
                int k;
                v.rst    = (i == 0) || ($urandom_range(0, 63) == 0);
                v.rs     = 5'($urandom_range(0, 3));
                v.rt     = 5'($urandom_range(0, 3));
                v.urs    = 1'($urandom);
                v.urt    = 1'($urandom);
                k        = $urandom_range(0, 7);
                v.jump   = (k == 0);
                v.jr     = (k == 1);
                v.exa    = 5'($urandom_range(0, 3));
                v.exrw   = 1'($urandom);
                v.exm2r  = 1'($urandom);
                v.mema   = 5'($urandom_range(0, 3));
                v.memrw  = 1'($urandom);
                v.memm2r = 1'($urandom);
                v.br     = ($urandom_range(0, 7) == 0);

                hex  = v.exrw && v.exm2r && (m(v.rs, v.exa, v.urs) || m(v.rt, v.exa, v.urt));
                hmem = v.memrw && v.memm2r && (m(v.rs, v.mema, v.urs) || m(v.rt, v.mema, v.urt));
                st = 1'b0;
                if (v.rst) begin
                    exp = O_RST;
                end else if (v.br) begin
                    exp = O_BR;
                end else if (cyc <= stall_until) begin
                    st = 1'b1;
                end else if (hex) begin
                    st = 1'b1;
                    stall_until = cyc + 1;
                end else if (hmem) begin
                    st = 1'b1;
                end else if (v.jump) begin
                    exp = O_JMP;
                end else if (v.jr) begin
                    exp = O_JR;
                end else begin
                    exp = O_RUN;
                end
                if (st) exp = O_STL;
                v.exp = exp;

                @(negedge clk);
                drive(v);
                #1;
                chk($sformatf("rnd%0d_outs", i), {26'd0, outs()}, {26'd0, exp});
                if (i > 0) begin
                    chk($sformatf("rnd%0d_stall_cnt", i), {16'd0, ifc.stall_cnt}, scnt);
                    chk($sformatf("rnd%0d_flush_cnt", i), {16'd0, ifc.flush_cnt}, fcnt);
                end

                if (v.rst || v.br) stall_until = -1;
                if (v.rst) begin
                    scnt = 0;
                    fcnt = 0;
                end else begin
                    if (st && scnt < 65535) scnt++;
                    if (exp[3] && fcnt < 65535) fcnt++;
                end
                cyc++;
            end
        end

        @(negedge clk);
        drive(idle_v);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
